// File: rtl/cluster_hpu_dispatcher_pkg.sv
// Shared types and defaults for the per-cluster HPU task dispatcher.
package cluster_hpu_dispatcher_pkg;

  localparam int unsigned NUM_HPUS_PER_CLUSTER = 8;

  typedef struct packed {
    logic [15:0] msgid;
    logic [31:0] handler_addr;
    logic [31:0] pkt_addr;
    logic [15:0] pkt_size;
  } handler_task_t;

  typedef struct packed {
    logic [15:0] msgid;
    logic [31:0] pkt_addr;
    logic [15:0] pkt_size;
  } feedback_descr_t;

endpackage

// File: rtl/cluster_hpu_dispatcher_free_picker.sv
// Round-robin first-free search: returns the first clear bit of busy_i at or after ptr_i, with wrap.
module cluster_hpu_dispatcher_free_picker
  import cluster_hpu_dispatcher_pkg::*;
#(
  parameter  int unsigned NUM_HPUS = NUM_HPUS_PER_CLUSTER,
  localparam int unsigned PTR_W    = $clog2(NUM_HPUS)
) (
  input  logic [NUM_HPUS-1:0] busy_i,
  input  logic [PTR_W-1:0]    ptr_i,
  output logic [NUM_HPUS-1:0] sel_o,
  output logic [PTR_W-1:0]    idx_o,
  output logic                any_free_o
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    sel_o      = '0;
    idx_o      = '0;
    any_free_o = 1'b0;
    cand       = '0;
    // NUM_HPUS is a power of two, so the pointer addition wraps naturally.
    for (int unsigned k = 0; k < NUM_HPUS; k++) begin
      cand = ptr_i + PTR_W'(k);
      if (!any_free_o && !busy_i[cand]) begin
        any_free_o  = 1'b1;
        idx_o       = cand;
        sel_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cluster_hpu_dispatcher.sv
// Per-cluster dispatcher: assigns scheduler tasks to free HPUs round-robin and
// returns HPU completions upstream through a small feedback FIFO.
module cluster_hpu_dispatcher
  import cluster_hpu_dispatcher_pkg::*;
#(
  parameter  int unsigned NUM_HPUS      = NUM_HPUS_PER_CLUSTER,
  parameter  int unsigned FB_FIFO_DEPTH = 4,
  localparam int unsigned CNT_W         = $clog2(NUM_HPUS) + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           task_valid_i,
  output logic                           task_ready_o,
  input  handler_task_t                  task_descr_i,
  output logic [NUM_HPUS-1:0]            hpu_task_valid_o,
  input  logic [NUM_HPUS-1:0]            hpu_task_ready_i,
  output handler_task_t                  hpu_task_o,
  input  logic [NUM_HPUS-1:0]            hpu_done_valid_i,
  output logic [NUM_HPUS-1:0]            hpu_done_ready_o,
  input  feedback_descr_t [NUM_HPUS-1:0] hpu_done_i,
  output logic                           feedback_valid_o,
  input  logic                           feedback_ready_i,
  output feedback_descr_t                feedback_o,
  output logic [CNT_W-1:0]               busy_count_o
);

  localparam int unsigned PTR_W   = $clog2(NUM_HPUS);
  localparam int unsigned FPTR_W  = $clog2(FB_FIFO_DEPTH);
  localparam int unsigned FCNT_W  = FPTR_W + 1;

  logic [NUM_HPUS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    busy_cnt_q, busy_cnt_d;
  logic [PTR_W-1:0]    rr_ptr_q;
  logic                out_valid_q;
  logic [NUM_HPUS-1:0] out_sel_q;
  handler_task_t       out_task_q;

  logic [PTR_W-1:0]    arb_ptr_q;
  logic                lock_q;
  logic [PTR_W-1:0]    lock_idx_q;

  feedback_descr_t     fb_mem_q [FB_FIFO_DEPTH];
  logic [FPTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0]   fifo_cnt_q;

  logic [NUM_HPUS-1:0] pick_sel;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic [NUM_HPUS-1:0] arb_sel;
  logic [PTR_W-1:0]    arb_idx;
  logic                arb_any;

  logic                use_lock, grant_any;
  logic [PTR_W-1:0]    grant_idx;
  logic [NUM_HPUS-1:0] grant_sel;
  logic                fifo_full, fifo_empty;
  logic                task_hs, disp_hs, done_hs, fb_pop;

  cluster_hpu_dispatcher_free_picker #(.NUM_HPUS(NUM_HPUS)) i_task_picker (
    .busy_i     (busy_q),
    .ptr_i      (rr_ptr_q),
    .sel_o      (pick_sel),
    .idx_o      (pick_idx),
    .any_free_o (pick_any)
  );

  // The same search over inverted valids is a round-robin arbiter for completions.
  cluster_hpu_dispatcher_free_picker #(.NUM_HPUS(NUM_HPUS)) i_done_arb (
    .busy_i     (~hpu_done_valid_i),
    .ptr_i      (arb_ptr_q),
    .sel_o      (arb_sel),
    .idx_o      (arb_idx),
    .any_free_o (arb_any)
  );

  assign fifo_full  = (fifo_cnt_q == FCNT_W'(FB_FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt_q == '0);

  // A stalled grant stays locked so the HPU that was offered first is served first.
  assign use_lock  = lock_q && hpu_done_valid_i[lock_idx_q];
  assign grant_idx = use_lock ? lock_idx_q : arb_idx;
  assign grant_any = use_lock || arb_any;

  always_comb begin
    grant_sel = arb_sel;
    if (use_lock) begin
      grant_sel             = '0;
      grant_sel[lock_idx_q] = 1'b1;
    end
  end

  assign task_ready_o     = !rst_i && pick_any && !out_valid_q;
  assign task_hs          = task_valid_i && task_ready_o;
  assign disp_hs          = out_valid_q && |(out_sel_q & hpu_task_ready_i);
  assign hpu_task_valid_o = (out_valid_q && !rst_i) ? out_sel_q : '0;
  assign hpu_task_o       = out_task_q;

  assign done_hs          = grant_any && !fifo_full && !rst_i;
  assign hpu_done_ready_o = done_hs ? grant_sel : '0;

  assign feedback_valid_o = !fifo_empty && !rst_i;
  assign feedback_o       = fb_mem_q[rd_ptr_q];
  assign fb_pop           = feedback_valid_o && feedback_ready_i;
  assign busy_count_o     = busy_cnt_q;

  // Accept and completion never target the same HPU, so both updates can apply at once.
  always_comb begin
    busy_d = busy_q;
    if (task_hs) busy_d = busy_d | pick_sel;
    if (done_hs) busy_d[grant_idx] = 1'b0;
    busy_cnt_d = '0;
    for (int unsigned i = 0; i < NUM_HPUS; i++) begin
      busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q      <= '0;
      busy_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      out_task_q  <= '0;
      arb_ptr_q   <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;

      if (task_hs) begin
        rr_ptr_q    <= pick_idx + PTR_W'(1);
        out_valid_q <= 1'b1;
        out_sel_q   <= pick_sel;
        out_task_q  <= task_descr_i;
      end else if (disp_hs) begin
        out_valid_q <= 1'b0;
      end

      if (done_hs) begin
        arb_ptr_q <= grant_idx + PTR_W'(1);
        lock_q    <= 1'b0;
      end else if (grant_any) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant_idx;
      end else begin
        lock_q <= 1'b0;
      end

      if (done_hs) begin
        wr_ptr_q <= (wr_ptr_q == FPTR_W'(FB_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + FPTR_W'(1);
      end
      if (fb_pop) begin
        rd_ptr_q <= (rd_ptr_q == FPTR_W'(FB_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + FPTR_W'(1);
      end
      case ({done_hs, fb_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (done_hs) fb_mem_q[wr_ptr_q] <= hpu_done_i[grant_idx];
  end

  // An HPU must only report completion for a task it was actually given.
  a_done_on_busy_only : assert property (@(posedge clk_i) disable iff (rst_i)
    ((hpu_done_valid_i & ~busy_q) == '0));

endmodule
